seven_segment_mux: RTL and testbench
====================================

SEVEN_SEGMENT_MUX -- requirements
Module: seven_segment_mux

Interface
REQ-001 Parameter: NUM_DIGITS, default 4, number of multiplexed digits (range 2..8).
REQ-002 Parameter: REFRESH_DIV, default 1000, clock cycles each digit is lit (range 2..2^20).
REQ-003 Parameter: ACTIVE_LOW, default 0; 1 inverts seg, dp_out and an at the output registers.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 bcd  in  4*NUM_DIGITS  packed BCD digits; nibble 0 = least significant digit.
REQ-007 dp  in  NUM_DIGITS  decimal-point request per digit; bit i belongs to digit i.
REQ-008 load  in  1  one-cycle strobe; captures bcd, dp and blank_lz into the pending register.
REQ-009 blank_lz  in  1  1 = blank leading zeros.
REQ-010 seg  out  7  segments {g,f,e,d,c,b,a} for the lit digit.
REQ-011 dp_out  out  1  decimal point for the lit digit.
REQ-012 an  out  NUM_DIGITS  one-hot digit enable; bit i lights digit i.
REQ-013 frame_start  out  1  one-cycle pulse when digit 0 becomes lit.
REQ-014 bcd_err  out  1  committed value holds a nibble greater than 9.

Function
REQ-015 Refresh counter counts 0..REFRESH_DIV-1 and wraps to 0; digit index idx advances on each wrap, NUM_DIGITS-1 -> 0.
REQ-016 seg, dp_out, an and frame_start are registered and reflect idx with 1-cycle latency.
REQ-017 Encoding (active-high), digits 0-9: 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex); nibbles 10-15 -> 40 (dash); blank -> 00.
REQ-018 load is always accepted (no backpressure); a later load before commit overwrites pending.
REQ-019 Commit: on the cycle where counter = REFRESH_DIV-1 and idx = NUM_DIGITS-1, a set pending flag copies pending into the display register and clears the flag; the next frame shows the new value (no tearing).
REQ-020 A load on the commit cycle is the value committed in that same cycle.
REQ-021 With no pending load, the display register holds its value indefinitely.
REQ-022 Leading-zero blanking: when committed blank_lz = 1, digits from NUM_DIGITS-1 downward whose nibble is 0 show seg = 00, stopping at the first non-zero nibble; digit 0 is never blanked.
REQ-023 dp_out follows committed dp[idx] and is unaffected by blanking.
REQ-024 an is exactly one-hot at all times after the first post-reset cycle.
REQ-025 frame_start = 1 for exactly one cycle per frame, concurrent with an = onehot(0); the frame period is NUM_DIGITS*REFRESH_DIV cycles.
REQ-026 bcd_err updates only at commit: it is set if any committed nibble > 9 and cleared by a commit with all nibbles valid.
REQ-027 With ACTIVE_LOW = 1, seg, dp_out and an are bitwise inverted; frame_start and bcd_err are never inverted.

Reset
REQ-028 While rst_n = 0 at a clock edge: counter = 0, idx = 0, display register = 0, pending flag = 0, committed blank_lz = 0, committed dp = 0.
REQ-029 Reset values at inactive level: seg = blank, dp_out = off, an = all off, frame_start = 0, bcd_err = 0.
REQ-030 A reset asserted mid-frame or mid-pending discards pending data; there is no commit on the reset cycle.
REQ-031 The first edge after rst_n rises presents an = onehot(0), seg = 3F, frame_start = 1.

Structure
REQ-032 Shared package seg7_pkg holds the 7-bit segment constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK).
REQ-033 Sub-module seg7_decode is a combinational nibble-to-segment decoder per REQ-017; instantiate it once, on the selected digit.
REQ-034 Width of the refresh counter is $clog2(REFRESH_DIV); width of idx is $clog2(NUM_DIGITS).

Verification (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=0)
REQ-035 Reset release, no load -> an steps 0001,0010,0100,1000 every 4 cycles, seg = 3F throughout, frame_start every 16 cycles.
REQ-036 load bcd=16'h1389 mid-frame -> old value held to frame end; next frame digits 0..3 show seg 6F,7F,4F,06.
REQ-037 load bcd=16'h0050, dp=4'b0010, blank_lz=1 -> frame shows 3F,6D(dp_out=1),00,00.
REQ-038 load bcd=16'h00A2 -> digit 1 shows 40, bcd_err=1 from commit; next load 16'h0002 commits and clears bcd_err.
REQ-039 Two loads in one frame, the second on the commit cycle -> only the second value is displayed, with no intermediate frame.
REQ-040 rst_n low for 1 cycle with a pending load -> all outputs at reset values, display = 0, pending value never shown.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display slice.
// Segment bit order is {g,f,e,d,c,b,a}; all patterns are active-high.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder; non-BCD nibbles show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed seven-segment driver with double-buffered display value,
// frame-aligned commit, leading-zero blanking and optional active-low outputs.
module seven_segment_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic                    bcd_err
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam bit INV   = (ACTIVE_LOW != 0);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BCD_W-1:0]      disp_bcd_q, pend_bcd_q;
  logic [NUM_DIGITS-1:0] disp_dp_q, pend_dp_q;
  logic                  disp_blz_q, pend_blz_q;
  logic                  pend_q, pend_d;
  logic                  err_q;
  logic [6:0]            seg_q;
  logic                  dp_out_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  fs_q;

  logic                  cnt_last, commit_tick, do_commit;
  logic [BCD_W-1:0]      src_bcd;
  logic [NUM_DIGITS-1:0] src_dp;
  logic                  src_blz, src_err;

  // Refresh timing and commit decision. A load on the commit cycle bypasses
  // the pending register so the freshest value lands in the next frame.
  always_comb begin
    cnt_last    = (cnt_q == CNT_LAST);
    commit_tick = cnt_last && (idx_q == IDX_LAST);
    do_commit   = commit_tick && (pend_q || load);
    cnt_d       = cnt_last ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    if (cnt_last) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    pend_d      = commit_tick ? 1'b0 : (load ? 1'b1 : pend_q);
    src_bcd     = load ? bcd      : pend_bcd_q;
    src_dp      = load ? dp       : pend_dp_q;
    src_blz     = load ? blank_lz : pend_blz_q;
    src_err     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (src_bcd[i*4 +: 4] > 4'd9) src_err = 1'b1;
    end
  end

  logic [NUM_DIGITS-1:0] blank_mask;
  logic                  zero_run;

  // Blanking walks down from the most significant digit; digit 0 stays lit.
  always_comb begin
    blank_mask = '0;
    zero_run   = disp_blz_q;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run && (disp_bcd_q[i*4 +: 4] == 4'd0);
      blank_mask[i] = zero_run;
    end
  end

  logic [3:0]            sel_nib;
  logic                  sel_dp, sel_blank, fs_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            dec_seg, seg_d;

  always_comb begin
    sel_nib   = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    an_d      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_nib   = disp_bcd_q[i*4 +: 4];
        sel_dp    = disp_dp_q[i];
        sel_blank = blank_mask[i];
        an_d[i]   = 1'b1;
      end
    end
    fs_d = (idx_q == '0) && (cnt_q == '0);
  end

  seg7_decode u_decode (
    .nibble_i (sel_nib),
    .seg_o    (dec_seg)
  );

  assign seg_d = sel_blank ? SEG_BLANK : dec_seg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_bcd_q <= '0;
      disp_dp_q  <= '0;
      disp_blz_q <= 1'b0;
      pend_bcd_q <= '0;
      pend_dp_q  <= '0;
      pend_blz_q <= 1'b0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      seg_q      <= INV ? ~SEG_BLANK : SEG_BLANK;
      dp_out_q   <= INV;
      an_q       <= INV ? '1 : '0;
      fs_q       <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      if (load) begin
        pend_bcd_q <= bcd;
        pend_dp_q  <= dp;
        pend_blz_q <= blank_lz;
      end
      if (do_commit) begin
        disp_bcd_q <= src_bcd;
        disp_dp_q  <= src_dp;
        disp_blz_q <= src_blz;
        err_q      <= src_err;
      end
      seg_q    <= INV ? ~seg_d  : seg_d;
      dp_out_q <= INV ? ~sel_dp : sel_dp;
      an_q     <= INV ? ~an_d   : an_d;
      fs_q     <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign dp_out      = dp_out_q;
  assign an          = an_q;
  assign frame_start = fs_q;
  assign bcd_err     = err_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Randomized scoreboard bench for seven_segment_mux (4 digits, 4-cycle dwell,
// active-high). A timeline model predicts every output cycle.
module tb_seven_segment_mux;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

  localparam logic [6:0] SEG_TAB [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  logic         clk;
  logic         rst_n;
  logic [15:0]  bcd;
  logic [3:0]   dp;
  logic         load;
  logic         blank_lz;
  logic [6:0]   seg;
  logic         dp_out;
  logic [3:0]   an;
  logic         frame_start;
  logic         bcd_err;

  seven_segment_mux #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (DIV),
    .ACTIVE_LOW  (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bcd         (bcd),
    .dp          (dp),
    .load        (load),
    .blank_lz    (blank_lz),
    .seg         (seg),
    .dp_out      (dp_out),
    .an          (an),
    .frame_start (frame_start),
    .bcd_err     (bcd_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {seg, dp_out, an, frame_start, bcd_err}
  logic [13:0] exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;

  // reference model: cycle k since reset release, committed and pending values
  int          k = 0;
  logic [15:0] m_bcd, p_bcd;
  logic [3:0]  m_dp, p_dp;
  logic        m_blz, p_blz, p_flag, m_err;

  function automatic logic has_bad(input logic [15:0] v);
    for (int i = 0; i < N; i++) begin
      if (((v >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  // driver: apply one cycle of inputs and push the predicted response
  task automatic step(input logic r, input logic ld, input logic [15:0] b,
                      input logic [3:0] d, input logic bl);
    int          pos, digit;
    logic [3:0]  nib;
    logic        blank;
    logic [6:0]  seg_e;
    logic [3:0]  an_e;
    logic        dp_e, fs_e;
    @(negedge clk);
    rst_n    = r;
    load     = ld;
    bcd      = b;
    dp       = d;
    blank_lz = bl;
    if (!r) begin
      exp_q.push_back(14'h0);
      k      = 0;
      m_bcd  = '0; m_dp = '0; m_blz = 1'b0; m_err = 1'b0;
      p_bcd  = '0; p_dp = '0; p_blz = 1'b0; p_flag = 1'b0;
    end else begin
      pos   = k % FRAME;
      digit = pos / DIV;
      nib   = 4'((m_bcd >> (4 * digit)) & 16'hF);
      blank = m_blz && (digit != 0) && ((m_bcd >> (4 * digit)) == 16'h0);
      seg_e = blank ? 7'h00 : SEG_TAB[nib];
      an_e  = 4'(1 << digit);
      dp_e  = m_dp[digit];
      fs_e  = (pos == 0);
      if (ld) begin
        p_bcd = b; p_dp = d; p_blz = bl; p_flag = 1'b1;
      end
      if (pos == FRAME - 1 && p_flag) begin
        m_bcd  = p_bcd; m_dp = p_dp; m_blz = p_blz;
        m_err  = has_bad(p_bcd);
        p_flag = 1'b0;
      end
      exp_q.push_back({seg_e, dp_e, an_e, fs_e, m_err});
      k++;
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
  endtask

  task automatic ld(input logic [15:0] b, input logic [3:0] d, input logic bl);
    step(1'b1, 1'b1, b, d, bl);
  endtask

  // monitor: compare after every rising edge
  always @(posedge clk) begin
    logic [13:0] e, a;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {seg, dp_out, an, frame_start, bcd_err};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs k=%0d t=%0t: got seg=%h dp=%b an=%b fs=%b err=%b, expected seg=%h dp=%b an=%b fs=%b err=%b",
                 k, $time, a[13:7], a[6], a[5:2], a[1], a[0],
                 e[13:7], e[6], e[5:2], e[1], e[0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; bcd = '0; dp = '0; blank_lz = 1'b0;
    m_bcd = '0; m_dp = '0; m_blz = 1'b0; m_err = 1'b0;
    p_bcd = '0; p_dp = '0; p_blz = 1'b0; p_flag = 1'b0;

    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 4'hF, 1'b0);
    repeat (40) idle();

    // mid-frame update, then decimal point with blanking
    repeat (5) idle();
    ld(16'h1389, 4'h0, 1'b0);
    repeat (40) idle();
    ld(16'h0050, 4'b0010, 1'b1);
    repeat (36) idle();

    // invalid nibble sets the error, a clean value clears it
    ld(16'h00A2, 4'h0, 1'b0);
    repeat (36) idle();
    ld(16'h0002, 4'h0, 1'b0);
    repeat (36) idle();

    // two loads in one frame, the second on the commit cycle
    ld(16'h4321, 4'h1, 1'b0);
    while (k % FRAME != FRAME - 1) idle();
    ld(16'h8765, 4'h8, 1'b0);
    repeat (36) idle();

    // reset with a load pending: pending value must never appear
    ld(16'h9999, 4'hF, 1'b0);
    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    repeat (36) idle();

    // randomized traffic with occasional resets and zero-heavy values
    repeat (500) begin
      logic [15:0] b;
      b = 16'($urandom);
      if ($urandom_range(0, 2) == 0) b = b & 16'h00FF;
      if ($urandom_range(0, 3) == 0) b = b & 16'h7777;
      if ($urandom_range(0, 149) == 0)
        step(1'b0, 1'b0, b, 4'($urandom), 1'($urandom));
      else
        step(1'b1, ($urandom_range(0, 11) == 0), b, 4'($urandom), 1'($urandom));
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
